// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_jogo
// Description : Moore control unit for the sequence-memory game. Steps the
//               datapath (counters E and L, play register R, comparator)
//               through rounds of growing length and reports win or loss.
//               Optional inactivity timer enabled by the macro
//               UNIDADE_CONTROLE_TIMEOUT_EN. When the macro is undefined, the
//               game waits indefinitely in ESPERA and db_timeout stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_jogo #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       jogar,
   input  logic       tem_jogada,
   input  logic       igual,
   input  logic       fim_seq,
   input  logic       fim_jogo,
   output logic       zera_E,
   output logic       conta_E,
   output logic       zera_L,
   output logic       conta_L,
   output logic       zera_R,
   output logic       registra_R,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      INICIA_SEQ  = 4'h2,
      ESPERA      = 4'h3,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROX_JOGADA = 4'h6,
      PROX_SEQ    = 4'h7,
      FIM_GANHOU  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_PERDEU  = 4'hE
   } estado_t;

   estado_t estado;
   estado_t prox;

   // A window shorter than two cycles leaves the timer with no usable width.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
      $error("TIMEOUT_CYCLES must be at least 2");
   end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

   logic [TIMER_W-1:0] timer;
   logic               timeout;

   // Inactivity timer: counts only while waiting for a play, cleared elsewhere
   // so every accepted play opens a fresh window.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (estado == ESPERA) begin
         timer <= timer + TIMER_W'(1);
      end else begin
         timer <= '0;
      end
   end

   assign timeout = (estado == ESPERA) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state logic; unused codes fall back to INICIAL.
   always_comb begin
      prox = estado;
      case (estado)
         INICIAL: begin
            if (jogar) prox = PREPARA;
         end
         PREPARA: begin
            prox = INICIA_SEQ;
         end
         INICIA_SEQ: begin
            prox = ESPERA;
         end
         ESPERA: begin
            // A press in the same cycle as the timeout takes priority.
            if (tem_jogada) begin
               prox = REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            end else if (timeout) begin
               prox = FIM_TIMEOUT;
`endif
            end
         end
         REGISTRA: begin
            prox = COMPARA;
         end
         COMPARA: begin
            if (!igual)         prox = FIM_PERDEU;
            else if (!fim_seq)  prox = PROX_JOGADA;
            else if (!fim_jogo) prox = PROX_SEQ;
            else                prox = FIM_GANHOU;
         end
         PROX_JOGADA: begin
            prox = ESPERA;
         end
         PROX_SEQ: begin
            prox = INICIA_SEQ;
         end
         FIM_GANHOU: begin
            if (jogar) prox = PREPARA;
         end
         FIM_PERDEU: begin
            if (jogar) prox = PREPARA;
         end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
         FIM_TIMEOUT: begin
            if (jogar) prox = PREPARA;
         end
`endif
         default: begin
            prox = INICIAL;
         end
      endcase
   end

   // State register with outputs registered as a decode of the next state,
   // so every output is a glitch-free function of the current state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= INICIAL;
         zera_E     <= 1'b0;
         conta_E    <= 1'b0;
         zera_L     <= 1'b0;
         conta_L    <= 1'b0;
         zera_R     <= 1'b0;
         registra_R <= 1'b0;
         pronto     <= 1'b0;
         ganhou     <= 1'b0;
         perdeu     <= 1'b0;
         db_timeout <= 1'b0;
         db_estado  <= 4'h0;
      end else begin
         estado     <= prox;
         zera_E     <= (prox == PREPARA) || (prox == INICIA_SEQ);
         conta_E    <= (prox == PROX_JOGADA);
         zera_L     <= (prox == PREPARA);
         conta_L    <= (prox == PROX_SEQ);
         zera_R     <= (prox == PREPARA);
         registra_R <= (prox == REGISTRA);
         ganhou     <= (prox == FIM_GANHOU);
         db_estado  <= prox;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
         pronto     <= (prox == FIM_GANHOU) || (prox == FIM_PERDEU) || (prox == FIM_TIMEOUT);
         perdeu     <= (prox == FIM_PERDEU) || (prox == FIM_TIMEOUT);
         db_timeout <= (prox == FIM_TIMEOUT);
`else
         pronto     <= (prox == FIM_GANHOU) || (prox == FIM_PERDEU);
         perdeu     <= (prox == FIM_PERDEU);
         db_timeout <= 1'b0;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_jogo
// Description : Self-checking bench for unidade_controle_jogo with a small
//               datapath model (counters E, L, register R, 4-word memory).
//               Expected states are queued before each edge and compared
//               after it. Exercises timeout paths when
//               UNIDADE_CONTROLE_TIMEOUT_EN is defined, otherwise checks that
//               ESPERA waits indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_jogo;

   logic       clock = 1'b0;
   logic       reset;
   logic       jogar;
   logic       tem_jogada;
   logic       igual;
   logic       fim_seq;
   logic       fim_jogo;
   logic       zera_E, conta_E, zera_L, conta_L, zera_R, registra_R;
   logic       pronto, ganhou, perdeu, db_timeout;
   logic [3:0] db_estado;

   unidade_controle_jogo #(.TIMEOUT_CYCLES(10)) dut (
      .clock      (clock),
      .reset      (reset),
      .jogar      (jogar),
      .tem_jogada (tem_jogada),
      .igual      (igual),
      .fim_seq    (fim_seq),
      .fim_jogo   (fim_jogo),
      .zera_E     (zera_E),
      .conta_E    (conta_E),
      .zera_L     (zera_L),
      .conta_L    (conta_L),
      .zera_R     (zera_R),
      .registra_R (registra_R),
      .pronto     (pronto),
      .ganhou     (ganhou),
      .perdeu     (perdeu),
      .db_timeout (db_timeout),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   // Output bundle: {zE, cE, zL, cL, zR, rR, pronto, ganhou, perdeu, db_timeout}
   logic [9:0] outs;
   assign outs = {zera_E, conta_E, zera_L, conta_L, zera_R, registra_R,
                  pronto, ganhou, perdeu, db_timeout};

   // Datapath model
   logic [3:0] mem [4];
   logic [1:0] e_m;
   logic [1:0] l_m;
   logic [3:0] r_m;
   logic [3:0] botao;

   int         cnt_E;
   int         cnt_L;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] exp_q [$];

   // Outputs required in each state
   function automatic logic [9:0] exp_outs(input logic [3:0] s);
      case (s)
         4'h1:    return 10'b1010100000;
         4'h2:    return 10'b1000000000;
         4'h4:    return 10'b0000010000;
         4'h6:    return 10'b0100000000;
         4'h7:    return 10'b0001000000;
         4'hA:    return 10'b0000001100;
         4'hE:    return 10'b0000001010;
         4'hD:    return 10'b0000001011;
         default: return 10'b0000000000;
      endcase
   endfunction

   task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive datapath flags, queue expected next state, advance,
   // update the datapath model from the outputs that were active, compare.
   task automatic tick(input string tag, input logic [3:0] exp_st);
      logic       ze, ce, zl, cl, zr, rr;
      logic [3:0] e;
      igual    = (r_m == mem[e_m]);
      fim_seq  = (e_m == l_m);
      fim_jogo = (l_m == 2'd3);
      exp_q.push_back(exp_st);
      ze = zera_E; ce = conta_E; zl = zera_L; cl = conta_L; zr = zera_R; rr = registra_R;
      @(posedge clock);
      if (ze) e_m = 2'd0; else if (ce) e_m = e_m + 2'd1;
      if (zl) l_m = 2'd0; else if (cl) l_m = l_m + 2'd1;
      if (zr) r_m = 4'd0; else if (rr) r_m = botao;
      if (ce) cnt_E++;
      if (cl) cnt_L++;
      #1;
      e = exp_q.pop_front();
      check_value({tag, "/estado"}, 16'(db_estado), 16'(e));
      check_value({tag, "/saidas"}, 16'(outs), 16'(exp_outs(e)));
   endtask

   task automatic start_game(input string tag);
      jogar = 1'b1;
      tick(tag, 4'h1);
      jogar = 1'b0;
      tick(tag, 4'h2);
      tick(tag, 4'h3);
   endtask

   // outcome: 0 next play, 1 next round, 2 win, 3 loss
   task automatic play(input string tag, input logic [3:0] b, input int outcome);
      botao      = b;
      tem_jogada = 1'b1;
      tick(tag, 4'h4);
      tem_jogada = 1'b0;
      tick(tag, 4'h5);
      case (outcome)
         0: begin tick(tag, 4'h6); tick(tag, 4'h3); end
         1: begin tick(tag, 4'h7); tick(tag, 4'h2); tick(tag, 4'h3); end
         2: tick(tag, 4'hA);
         default: tick(tag, 4'hE);
      endcase
   endtask

   initial begin
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
      e_m = '0; l_m = '0; r_m = '0; botao = '0;
      cnt_E = 0; cnt_L = 0;
      reset = 1'b0; jogar = 1'b0; tem_jogada = 1'b0;
      igual = 1'b0; fim_seq = 1'b0; fim_jogo = 1'b0;

      // Reset state
      #2;
      check_value("rst0/estado", 16'(db_estado), 16'h0);
      check_value("rst0/saidas", 16'(outs), 16'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) tick("idle", 4'h0);

      // Start and full win
      start_game("start");
      cnt_E = 0; cnt_L = 0;
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p <= r; p++) begin
            play($sformatf("win_r%0d_p%0d", r, p), mem[p],
                 (p < r) ? 0 : ((r < 3) ? 1 : 2));
         end
      end
      check_value("win/conta_L", 16'(cnt_L), 16'd3);
      check_value("win/conta_E", 16'(cnt_E), 16'd6);
      check_value("win/pronto",  16'(pronto), 16'd1);
      check_value("win/ganhou",  16'(ganhou), 16'd1);
      check_value("win/perdeu",  16'(perdeu), 16'd0);
      repeat (3) tick("win_hold", 4'hA);

      // Wrong play in round 2; jogar held through PREPARA/INICIA_SEQ is ignored
      start_game("restart1");
      play("wr_r0_p0", mem[0], 1);
      play("wr_r1_p0", mem[0], 0);
      play("wr_r1_p1", 4'b1111, 3);
      check_value("lose/perdeu", 16'(perdeu), 16'd1);
      check_value("lose/ganhou", 16'(ganhou), 16'd0);
      repeat (2) tick("lose_hold", 4'hE);
      jogar = 1'b1;
      tick("restart2", 4'h1);
      tick("restart2_held", 4'h2);
      tick("restart2_held", 4'h3);
      jogar = 1'b0;
      repeat (2) tick("wait", 4'h3);

      // Asynchronous reset mid-ESPERA
      reset = 1'b0;
      #2;
      check_value("rst_mid/estado", 16'(db_estado), 16'h0);
      check_value("rst_mid/saidas", 16'(outs), 16'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (20) tick("rst_idle", 4'h0);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      // Timeout exactly TIMEOUT_CYCLES edges after entering ESPERA
      start_game("to_start");
      repeat (9) tick("to_wait", 4'h3);
      tick("to_fire", 4'hD);
      check_value("to/db_timeout", 16'(db_timeout), 16'd1);
      tick("to_hold", 4'hD);
      // Press at count 9 beats the timeout
      start_game("to_restart");
      repeat (9) tick("to_wait2", 4'h3);
      play("to_last", mem[0], 1);
`else
      // Without the timer ESPERA waits indefinitely
      start_game("nt_start");
      for (int i = 0; i < 20000; i++) tick("nt_hold", 4'h3);
      check_value("nt/db_timeout", 16'(db_timeout), 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
